// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, DIGIT bits per clock.
// A chain of DIGIT full-subtractor cells handles one digit per RUN cycle.
// The borrow between digits is registered.
// Optional feature macro: SUB_OVERFLOW_EN adds the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   part_r;
  logic               br_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic [DIGIT-1:0]   dig_s;
  logic               br_s;
  logic [WIDTH-1:0]   part_s;
  logic               accept_s;
  logic               last_s;
`ifdef SUB_OVERFLOW_EN
  logic               a_msb_r;
  logic               b_msb_r;
  logic               ovf_r;
`endif

  // One full-subtractor cell; returns {borrow_out, difference}.
  function automatic logic [1:0] fsub(input logic ai, input logic bi, input logic bri);
    fsub = {(~ai & bi) | (~(ai ^ bi) & bri), ai ^ bi ^ bri};
  endfunction

  // A start is honoured in IDLE and DONE; the last RUN cycle completes the result.
  assign accept_s = start && (state_r != RUN);
  assign last_s   = (state_r == RUN) && (cnt_r == LAST);

  // Ripple the registered borrow through DIGIT cells and merge the digit into the partial result.
  always_comb begin
    logic [1:0]         cell_v;
    logic               br_v;
    logic [WIDTH+DIGIT-1:0] cat_v;
    dig_s  = '0;
    br_v   = br_r;
    cell_v = 2'b00;
    for (int i = 0; i < DIGIT; i++) begin
      cell_v   = fsub(a_sh_r[i], b_sh_r[i], br_v);
      dig_s[i] = cell_v[0];
      br_v     = cell_v[1];
    end
    br_s   = br_v;
    cat_v  = {dig_s, part_r};
    part_s = cat_v[WIDTH+DIGIT-1:DIGIT];
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST) state_s = DONE;
        else               state_s = RUN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand capture, per-digit shifting and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      part_r   <= '0;
      br_r     <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      ovf_r    <= 1'b0;
`endif
    end else begin
      busy_r <= (state_s == RUN);
      done_r <= (state_s == DONE);
      if (accept_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b;
        br_r    <= bin;
        part_r  <= '0;
        cnt_r   <= '0;
`ifdef SUB_OVERFLOW_EN
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b[WIDTH-1];
`endif
      end else if (state_r == RUN) begin
        a_sh_r <= a_sh_r >> DIGIT;
        b_sh_r <= b_sh_r >> DIGIT;
        br_r   <= br_s;
        part_r <= part_s;
        cnt_r  <= cnt_r + CW'(1);
        if (last_s) begin
          diff_r   <= part_s;
          borrow_r <= br_s;
`ifdef SUB_OVERFLOW_EN
          ovf_r    <= (a_msb_r ^ b_msb_r) & (part_s[WIDTH-1] ^ a_msb_r);
`endif
        end
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign diff   = diff_r;
  assign borrow = borrow_r;
`ifdef SUB_OVERFLOW_EN
  assign ovf    = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: four instances (W1D1, W8D1, W8D4, W8D2).
// Directed stimulus pushes hand-computed results; a monitor pops them on done.
module tb_serial_subtractor;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic [3:0] bin_v;
  logic [7:0] a_v [4];
  logic [7:0] b_v [4];
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [3:0] bo_v;
  logic [3:0] ov_v;
  logic [0:0] d0;
  logic [7:0] d1, d2, d3;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt [4];
  int   steps [4] = '{1, 8, 2, 4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u0 (
`ifdef SUB_OVERFLOW_EN
    .ovf(ov_v[0]),
`endif
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][0:0]), .b(b_v[0][0:0]),
    .bin(bin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .diff(d0), .borrow(bo_v[0]));
  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u1 (
`ifdef SUB_OVERFLOW_EN
    .ovf(ov_v[1]),
`endif
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .bin(bin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .diff(d1), .borrow(bo_v[1]));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u2 (
`ifdef SUB_OVERFLOW_EN
    .ovf(ov_v[2]),
`endif
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .bin(bin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .diff(d2), .borrow(bo_v[2]));
  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u3 (
`ifdef SUB_OVERFLOW_EN
    .ovf(ov_v[3]),
`endif
    .clk(clk), .rst(rst), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]),
    .bin(bin_v[3]), .busy(busy_v[3]), .done(done_v[3]), .diff(d3), .borrow(bo_v[3]));

`ifndef SUB_OVERFLOW_EN
  assign ov_v = 4'd0;
`endif

  function automatic logic [7:0] dget(input int k);
    case (k)
      0:       dget = {7'd0, d0};
      1:       dget = d1;
      2:       dget = d2;
      default: dget = d3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; start is accepted on the next posedge.
  task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    a_v[k] = av;
    b_v[k] = bv;
    bin_v[k] = bi;
    start_v[k] = 1'b1;
    e.id = k; e.d = ed; e.bo = eb; e.ov = eo; e.cyc = cyc + 1 + steps[k];
    sbq.push_back(e);
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    chk("done_timeout", sbq.size(), 0);
    sbq.delete();
  endtask

  // Monitor: pop and compare whenever any instance presents done.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (busy_v[k]) busy_cnt[k]++;
      if (done_v[k]) begin
        if (sbq.size() == 0 || sbq[0].id != k) begin
          chk("unexpected_done", k, 32'hFFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("diff", dget(k), e.d);
          chk("borrow", bo_v[k], e.bo);
          chk("done_cycle", cyc, e.cyc);
`ifdef SUB_OVERFLOW_EN
          if (k == 3) chk("ovf", ov_v[k], e.ov);
`endif
        end
      end
    end
  end

  initial begin
    logic [7:0] tbl_d;
    logic [7:0] tbl_b;
    logic [2:0] v;
    tbl_d = 8'b1001_0110;
    tbl_b = 8'b1000_1110;
    rst = 1'b1;
    start_v = 4'd0;
    bin_v = 4'd0;
    for (int k = 0; k < 4; k++) begin
      a_v[k] = 8'd0; b_v[k] = 8'd0; busy_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_busy", busy_v[k], 1'b0);
      chk("rst_done", done_v[k], 1'b0);
      chk("rst_diff", dget(k), 8'd0);
      chk("rst_borrow", bo_v[k], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=1 full-subtractor truth table, index = {a, b, bin}.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      issue(0, {7'd0, v[2]}, {7'd0, v[1]}, v[0], {7'd0, tbl_d[i]}, tbl_b[i], 1'b0);
      wait_empty();
    end

    // WIDTH=8, DIGIT=1 basic cases plus busy duration.
    busy_cnt[1] = 0;
    issue(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_empty();
    chk("busy_cycles", busy_cnt[1], 8);
    issue(1, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    wait_empty();
    issue(1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_empty();

    // start during RUN is ignored.
    issue(1, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a_v[1] = 8'hFF; b_v[1] = 8'h00; bin_v[1] = 1'b1; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_empty();
    repeat (10) @(negedge clk);
    chk("ignored_start_diff", d1, 8'h4B);
    chk("ignored_start_busy", busy_v[1], 1'b0);

    // Reset mid-RUN aborts the operation.
    issue(1, 8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    sbq.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy_v[1], 1'b0);
    chk("abort_done", done_v[1], 1'b0);
    chk("abort_diff", d1, 8'd0);
    chk("abort_borrow", bo_v[1], 1'b0);
    repeat (12) @(negedge clk);
    chk("abort_busy_later", busy_v[1], 1'b0);

    // WIDTH=8, DIGIT=4 with a back-to-back start in the DONE cycle.
    issue(2, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done_present", done_v[2], 1'b1);
    issue(2, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    chk("b2b_held_diff", d2, 8'h4B);
    chk("b2b_busy", busy_v[2], 1'b1);
    wait_empty();
    chk("b2b_final_diff", d2, 8'hF0);

    // WIDTH=8, DIGIT=2 signed-overflow cases.
    issue(3, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    wait_empty();
    issue(3, 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);
    wait_empty();

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised multi-cycle subtractor. Computes diff = a - b - bin over WIDTH bits, DIGIT bits per clock, using a chain of DIGIT full-subtractor cells with the borrow registered between digits.
- Used where a full-width combinational borrow chain is too costly. Trades latency (WIDTH/DIGIT cycles) for area.
- Start/done handshake. Result is held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥1.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly. STEPS = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled on a rising edge when the block is not busy
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- bin  input  1  borrow-in; captured on the accepting edge
- busy  output  1  high while the operation is in progress (RUN state)
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  result register
- borrow  output  1  final borrow-out: 1 when a < b + bin, treating the operands as unsigned
- ovf  output  1  signed overflow; present only with SUB_OVERFLOW_EN

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0.
  - Reset overrides start.
  - Reset mid-RUN aborts the operation with no done pulse.
- FSM states:
  - IDLE: start=1 → load a, b, bin into internal shift registers, step count=0, go to RUN.
  - RUN: busy=1. Each edge processes the low DIGIT bits of the shift registers:
    - d_i = a_i ^ b_i ^ br_i
    - br_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & br_i)
    - br_0 is the registered borrow from the previous digit.
    - Shift the operand registers right by DIGIT.
    - Shift the digit result into the partial register from the MSB side.
    - After the STEPS-th digit, transfer the partial register to diff and the final borrow to borrow, then go to DONE.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted as in IDLE, giving back-to-back operation. Otherwise go to IDLE.
- Latency:
  - start accepted at edge 0 → done=1 after edge STEPS.
  - Throughput with back-to-back starts: one result per STEPS+1 cycles.
- start while busy=1 is ignored. It is neither queued nor allowed to disturb the captured operands.
- diff and borrow change only at the completion edge. They stay stable through RUN of the next operation until its own completion edge.
- WIDTH=DIGIT: STEPS=1, single RUN cycle.
- No wrap-around hazard: the step counter is sized for STEPS and clears on each accepted start.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- Defined:
  - Port ovf exists.
  - ovf is set at the completion edge to (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured operands. bin is included in diff.
  - ovf is held with diff and reset to 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=1, DIGIT=1; all 8 combinations of a, b, bin → diff/borrow match the full-subtractor truth table. Check 1-0-1 → diff 0, borrow 0 and 0-1-1 → diff 0, borrow 1. done arrives 1 cycle after the start edge.
- WIDTH=8, DIGIT=1:
  - a=0x05, b=0x03, bin=0 → diff=0x02, borrow=0, done exactly 8 cycles after the start edge, busy high for 8 cycles.
  - a=0x03, b=0x05, bin=0 → diff=0xFE, borrow=1.
  - a=0x00, b=0x00, bin=1 → diff=0xFF, borrow=1.
- WIDTH=8, DIGIT=4: a=0xA5, b=0x5A, bin=0 → diff=0x4B, borrow=0, done 2 cycles after start. Back-to-back start in the DONE cycle with a=0x10, b=0x20 → diff=0xF0, borrow=1, and 0x4B stays held until that completion.
- WIDTH=8, DIGIT=1:
  - start pulsed again at cycle 3 of an operation with different operands → ignored; original result produced on schedule.
  - rst at cycle 4 → busy=0, no done, diff=0.
- SUB_OVERFLOW_EN, WIDTH=8, DIGIT=2:
  - a=0x80, b=0x01 → diff=0x7F, ovf=1, borrow=0.
  - a=0x7F, b=0x01 → diff=0x7E, ovf=0.
